// File: rtl/atm_account_server.sv
// -----------------------------------------------------------------------------
// atm_account_server
//
// Purpose:
//   Single-account ATM back end. Accepts one request at a time over a
//   valid/ready channel, evaluates it in the acceptance cycle and returns the
//   response on a valid/ready channel starting in the following cycle.
//   Handles PIN verification with lockout after MAX_ATTEMPTS bad PINs,
//   deposits with overflow protection, withdrawals with a face-check limit,
//   balance queries and session close. The optional statement history streams
//   the last HIST_DEPTH non-zero OK deposits/withdrawals newest-first.
//
// Configuration:
//   ATM_SERVER_HISTORY_EN - when defined, the history buffer and the STMT
//   state are built. When undefined, STATEMENT answers a single UNSUPPORTED
//   beat and no history storage exists.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-high reset
//   req_valid/ready request handshake (ready only while idle)
//   req_op          0 VERIFY_PIN, 1 DEPOSIT, 2 WITHDRAW, 3 BALANCE,
//                   4 STATEMENT, 5 END_SESSION, 6-7 reserved
//   req_pin         PIN for VERIFY_PIN
//   req_amount      amount for DEPOSIT / WITHDRAW
//   req_face_ok     face verified, sampled with the request
//   admin_unlock    one-cycle pulse that clears the lock and attempt counter
//   rsp_valid/ready response beat handshake
//   rsp_status      0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 NEED_FACE,
//                   5 OVERFLOW, 6 NO_SESSION, 7 UNSUPPORTED
//   rsp_data        balance on OK single-beat responses, entry amount on
//                   statement beats, 0 on every non-OK response
//   rsp_kind        statement entry type (1 deposit, 0 withdrawal)
//   rsp_last        final beat of the response
//   account_locked  lock flag
//   session_open    PIN verified, session active
// -----------------------------------------------------------------------------
module atm_account_server #(
    parameter int unsigned BAL_W        = 16,
    parameter logic [15:0] PIN_VALUE    = 16'h1234,
    parameter int unsigned INIT_BALANCE = 100,
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned LIMIT        = 10,
    parameter int unsigned HIST_DEPTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [15:0]      req_pin,
    input  logic [BAL_W-1:0] req_amount,
    input  logic             req_face_ok,
    input  logic             admin_unlock,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_status,
    output logic [BAL_W-1:0] rsp_data,
    output logic             rsp_kind,
    output logic             rsp_last,
    output logic             account_locked,
    output logic             session_open
);

    localparam logic [2:0] OP_VERIFY    = 3'd0;
    localparam logic [2:0] OP_DEPOSIT   = 3'd1;
    localparam logic [2:0] OP_WITHDRAW  = 3'd2;
    localparam logic [2:0] OP_BALANCE   = 3'd3;
    localparam logic [2:0] OP_STATEMENT = 3'd4;
    localparam logic [2:0] OP_END       = 3'd5;

    localparam logic [2:0] ST_OK           = 3'd0;
    localparam logic [2:0] ST_BAD_PIN      = 3'd1;
    localparam logic [2:0] ST_LOCKED       = 3'd2;
    localparam logic [2:0] ST_INSUFFICIENT = 3'd3;
    localparam logic [2:0] ST_NEED_FACE    = 3'd4;
    localparam logic [2:0] ST_OVERFLOW     = 3'd5;
    localparam logic [2:0] ST_NO_SESSION   = 3'd6;
    localparam logic [2:0] ST_UNSUPPORTED  = 3'd7;

    localparam int unsigned ATT_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned ATT_W1 = ATT_W + 1;
    localparam logic [ATT_W:0]     MAX_ATT   = ATT_W1'(MAX_ATTEMPTS);
    localparam logic [BAL_W-1:0]   LIMIT_V   = BAL_W'(LIMIT);
    localparam logic [BAL_W-1:0]   INIT_BAL  = BAL_W'(INIT_BALANCE);

    typedef enum logic [1:0] {
        IDLE,
        RESP
`ifdef ATM_SERVER_HISTORY_EN
        , STMT
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [BAL_W-1:0]   balance_q, balance_d;
    logic               locked_q, locked_d;
    logic               session_q, session_d;
    logic [ATT_W-1:0]   attempts_q, attempts_d;
    logic [2:0]         rsp_status_q, rsp_status_d;
    logic [BAL_W-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_kind_q, rsp_kind_d;
    logic               rsp_last_q, rsp_last_d;

    logic [BAL_W:0]     dep_sum;
    logic [ATT_W:0]     att_inc;
    logic               pin_fail;

    assign dep_sum = {1'b0, balance_q} + {1'b0, req_amount};
    assign att_inc = {1'b0, attempts_q} + 1'b1;

`ifdef ATM_SERVER_HISTORY_EN
    localparam int unsigned IDX_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(HIST_DEPTH + 1);

    // Entry 0 is always the newest; older entries shift towards the end and
    // the oldest falls off once the buffer is full.
    logic [BAL_W-1:0]   hist_amt_q [HIST_DEPTH];
    logic               hist_kind_q [HIST_DEPTH];
    logic [CNT_W-1:0]   hist_cnt_q;
    logic [IDX_W-1:0]   beat_q, beat_d;
    logic               hist_push;
    logic               push_kind;
`endif

    assign req_ready      = (state_q == IDLE);
    assign rsp_valid      = (state_q != IDLE);
    assign rsp_status     = rsp_status_q;
    assign rsp_data       = rsp_data_q;
    assign rsp_kind       = rsp_kind_q;
    assign rsp_last       = rsp_last_q;
    assign account_locked = locked_q;
    assign session_open   = session_q;

    // Next-state and request evaluation. A request is fully evaluated in its
    // acceptance cycle; the registered response is then held until consumed.
    always_comb begin
        state_d      = state_q;
        balance_d    = balance_q;
        locked_d     = locked_q;
        session_d    = session_q;
        attempts_d   = attempts_q;
        rsp_status_d = rsp_status_q;
        rsp_data_d   = rsp_data_q;
        rsp_kind_d   = rsp_kind_q;
        rsp_last_d   = rsp_last_q;
        pin_fail     = 1'b0;
`ifdef ATM_SERVER_HISTORY_EN
        beat_d       = beat_q;
        hist_push    = 1'b0;
        push_kind    = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d      = RESP;
                    rsp_status_d = ST_OK;
                    rsp_data_d   = '0;
                    rsp_kind_d   = 1'b0;
                    rsp_last_d   = 1'b1;
                    if (req_op == OP_VERIFY) begin
                        if (locked_q) begin
                            rsp_status_d = ST_LOCKED;
                        end else if (req_pin == PIN_VALUE) begin
                            session_d  = 1'b1;
                            attempts_d = '0;
                            rsp_data_d = balance_q;
                        end else begin
                            pin_fail   = 1'b1;
                            attempts_d = att_inc[ATT_W-1:0];
                            if (att_inc >= MAX_ATT && !admin_unlock) begin
                                locked_d     = 1'b1;
                                rsp_status_d = ST_LOCKED;
                            end else begin
                                rsp_status_d = ST_BAD_PIN;
                            end
                        end
                    end else if (req_op <= OP_STATEMENT && !session_q) begin
                        rsp_status_d = ST_NO_SESSION;
                    end else begin
                        case (req_op)
                            OP_DEPOSIT: begin
                                if (dep_sum[BAL_W]) begin
                                    rsp_status_d = ST_OVERFLOW;
                                end else begin
                                    balance_d  = dep_sum[BAL_W-1:0];
                                    rsp_data_d = dep_sum[BAL_W-1:0];
`ifdef ATM_SERVER_HISTORY_EN
                                    hist_push  = (req_amount != '0);
                                    push_kind  = 1'b1;
`endif
                                end
                            end
                            OP_WITHDRAW: begin
                                if (req_amount > LIMIT_V && !req_face_ok) begin
                                    rsp_status_d = ST_NEED_FACE;
                                end else if (req_amount > balance_q) begin
                                    rsp_status_d = ST_INSUFFICIENT;
                                end else begin
                                    balance_d  = balance_q - req_amount;
                                    rsp_data_d = balance_q - req_amount;
`ifdef ATM_SERVER_HISTORY_EN
                                    hist_push  = (req_amount != '0);
                                    push_kind  = 1'b0;
`endif
                                end
                            end
                            OP_BALANCE: begin
                                rsp_data_d = balance_q;
                            end
                            OP_STATEMENT: begin
`ifdef ATM_SERVER_HISTORY_EN
                                // An empty history still answers one OK beat
                                // with zero data, served from RESP.
                                if (hist_cnt_q != '0) begin
                                    state_d    = STMT;
                                    beat_d     = '0;
                                    rsp_data_d = hist_amt_q[0];
                                    rsp_kind_d = hist_kind_q[0];
                                    rsp_last_d = (hist_cnt_q == CNT_W'(1));
                                end
`else
                                rsp_status_d = ST_UNSUPPORTED;
`endif
                            end
                            OP_END: begin
                                session_d  = 1'b0;
                                rsp_data_d = balance_q;
                            end
                            default: begin
                                rsp_status_d = ST_UNSUPPORTED;
                            end
                        endcase
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef ATM_SERVER_HISTORY_EN
            STMT: begin
                // Each handshake advances to the next older entry.
                if (rsp_ready) begin
                    if (rsp_last_q) begin
                        state_d = IDLE;
                    end else begin
                        beat_d     = beat_q + 1'b1;
                        rsp_data_d = hist_amt_q[beat_d];
                        rsp_kind_d = hist_kind_q[beat_d];
                        rsp_last_d = (CNT_W'(beat_d) == hist_cnt_q - 1'b1);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Unlock wins over a lockout raised by a coincident bad PIN; that
        // request then reports BAD_PIN.
        if (admin_unlock) begin
            locked_d   = 1'b0;
            attempts_d = '0;
            if (pin_fail) begin
                rsp_status_d = ST_BAD_PIN;
            end
        end

        if (locked_d) begin
            session_d = 1'b0;
        end
    end

    // Main state register; reset drops any in-flight response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            balance_q    <= INIT_BAL;
            locked_q     <= 1'b0;
            session_q    <= 1'b0;
            attempts_q   <= '0;
            rsp_status_q <= 3'd0;
            rsp_data_q   <= '0;
            rsp_kind_q   <= 1'b0;
            rsp_last_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            balance_q    <= balance_d;
            locked_q     <= locked_d;
            session_q    <= session_d;
            attempts_q   <= attempts_d;
            rsp_status_q <= rsp_status_d;
            rsp_data_q   <= rsp_data_d;
            rsp_kind_q   <= rsp_kind_d;
            rsp_last_q   <= rsp_last_d;
        end
    end

`ifdef ATM_SERVER_HISTORY_EN
    // History shift register and statement beat index.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_cnt_q <= '0;
            beat_q     <= '0;
            for (int i = 0; i < int'(HIST_DEPTH); i++) begin
                hist_amt_q[i]  <= '0;
                hist_kind_q[i] <= 1'b0;
            end
        end else begin
            beat_q <= beat_d;
            if (hist_push) begin
                for (int i = int'(HIST_DEPTH) - 1; i > 0; i--) begin
                    hist_amt_q[i]  <= hist_amt_q[i-1];
                    hist_kind_q[i] <= hist_kind_q[i-1];
                end
                hist_amt_q[0]  <= req_amount;
                hist_kind_q[0] <= push_kind;
                if (hist_cnt_q != CNT_W'(HIST_DEPTH)) begin
                    hist_cnt_q <= hist_cnt_q + 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_atm_account_server.sv
// -----------------------------------------------------------------------------
// tb_atm_account_server
//
// Purpose:
//   Self-checking bench for atm_account_server. A directed table of requests
//   with hand-computed results, hand-written multi-cycle sequences (unlock
//   race, stalled statement, reset mid-response) and a randomized phase
//   checked against a behavioural account model built on plain integers and
//   a queue of history entries. Follows ATM_SERVER_HISTORY_EN like the DUT.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_atm_account_server;

    localparam int          BAL_W        = 16;
    localparam logic [15:0] PIN_VALUE    = 16'h1234;
    localparam int          INIT_BALANCE = 100;
    localparam int          MAX_ATTEMPTS = 3;
    localparam int          LIMIT        = 10;
    localparam int          HIST_DEPTH   = 4;
    localparam int          MAX_BAL      = (1 << BAL_W) - 1;

    localparam logic [2:0] OP_VERIFY = 3'd0, OP_DEPOSIT = 3'd1, OP_WITHDRAW = 3'd2,
                           OP_BALANCE = 3'd3, OP_STATEMENT = 3'd4, OP_END = 3'd5;
    localparam logic [2:0] ST_OK = 3'd0, ST_BAD_PIN = 3'd1, ST_LOCKED = 3'd2,
                           ST_INSUFFICIENT = 3'd3, ST_NEED_FACE = 3'd4,
                           ST_OVERFLOW = 3'd5, ST_NO_SESSION = 3'd6,
                           ST_UNSUPPORTED = 3'd7;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [15:0]      req_pin;
    logic [BAL_W-1:0] req_amount;
    logic             req_face_ok;
    logic             admin_unlock;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2:0]       rsp_status;
    logic [BAL_W-1:0] rsp_data;
    logic             rsp_kind;
    logic             rsp_last;
    logic             account_locked;
    logic             session_open;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    atm_account_server dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_pin        (req_pin),
        .req_amount     (req_amount),
        .req_face_ok    (req_face_ok),
        .admin_unlock   (admin_unlock),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_status     (rsp_status),
        .rsp_data       (rsp_data),
        .rsp_kind       (rsp_kind),
        .rsp_last       (rsp_last),
        .account_locked (account_locked),
        .session_open   (session_open)
    );

    // Behavioural account model
    typedef struct {
        bit kind;
        int amount;
    } histEntry_t;

    typedef struct {
        logic [2:0] status;
        int         data;
        bit         kind;
        bit         last;
    } beat_t;

    int         mBalance;
    bit         mLocked;
    bit         mSession;
    int         mAttempts;
    histEntry_t mHist[$];
    beat_t      expBeats[$];
    beat_t      gotBeats[$];

    typedef struct {
        logic [2:0]  op;
        logic [15:0] pin;
        int          amt;
        bit          face;
        logic [2:0]  expStatus;
        int          expData;
        bit          expLocked;
        bit          expSession;
    } vec_t;

    vec_t vecs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    function automatic void modelReset();
        mBalance  = INIT_BALANCE;
        mLocked   = 1'b0;
        mSession  = 1'b0;
        mAttempts = 0;
        mHist.delete();
    endfunction

    function automatic void modelStep(input logic [2:0] op, input logic [15:0] pin,
                                      input int amt, input bit face, input bit unlock);
        beat_t b;
        bit    multi;
        b.status = ST_OK;
        b.data   = 0;
        b.kind   = 1'b0;
        b.last   = 1'b1;
        multi    = 1'b0;
        expBeats.delete();
        if (op == OP_VERIFY) begin
            if (mLocked) begin
                b.status = ST_LOCKED;
            end else if (pin == PIN_VALUE) begin
                mSession  = 1'b1;
                mAttempts = 0;
                b.data    = mBalance;
            end else begin
                mAttempts++;
                if (!unlock && mAttempts >= MAX_ATTEMPTS) begin
                    mLocked  = 1'b1;
                    mSession = 1'b0;
                    b.status = ST_LOCKED;
                end else begin
                    b.status = ST_BAD_PIN;
                end
            end
        end else if (op >= OP_DEPOSIT && op <= OP_STATEMENT && !mSession) begin
            b.status = ST_NO_SESSION;
        end else begin
            case (op)
                OP_DEPOSIT: begin
                    if (mBalance + amt > MAX_BAL) b.status = ST_OVERFLOW;
                    else begin
                        mBalance += amt;
                        b.data = mBalance;
                        if (amt != 0) mHist.push_front('{1'b1, amt});
                    end
                end
                OP_WITHDRAW: begin
                    if (amt > LIMIT && !face) b.status = ST_NEED_FACE;
                    else if (amt > mBalance) b.status = ST_INSUFFICIENT;
                    else begin
                        mBalance -= amt;
                        b.data = mBalance;
                        if (amt != 0) mHist.push_front('{1'b0, amt});
                    end
                end
                OP_BALANCE: b.data = mBalance;
                OP_STATEMENT: begin
`ifdef ATM_SERVER_HISTORY_EN
                    if (mHist.size() > 0) begin
                        multi = 1'b1;
                        for (int i = 0; i < mHist.size(); i++) begin
                            beat_t e;
                            e.status = ST_OK;
                            e.data   = mHist[i].amount;
                            e.kind   = mHist[i].kind;
                            e.last   = (i == mHist.size() - 1);
                            expBeats.push_back(e);
                        end
                    end
`else
                    b.status = ST_UNSUPPORTED;
`endif
                end
                OP_END: begin
                    mSession = 1'b0;
                    b.data   = mBalance;
                end
                default: b.status = ST_UNSUPPORTED;
            endcase
        end
        while (mHist.size() > HIST_DEPTH) void'(mHist.pop_back());
        if (unlock) begin
            mLocked   = 1'b0;
            mAttempts = 0;
        end
        if (!multi) expBeats.push_back(b);
    endfunction

    function automatic logic [31:0] packExp(input beat_t b);
        logic [15:0] d;
        d = b.data[15:0];
        return {10'd0, 1'b1, b.status, b.kind, b.last, d};
    endfunction

    function automatic logic [31:0] packAct();
        return {10'd0, rsp_valid, rsp_status, rsp_kind, rsp_last, rsp_data};
    endfunction

    // Offers one request at a negedge; returns at the negedge after acceptance.
    task automatic driveReq(input logic [2:0] op, input logic [15:0] pin,
                            input int amt, input bit face, input bit unlock);
        int waitCycles = 0;
        while (!req_ready && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        if (!req_ready) checkOutput("req_ready timeout", 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_op       = op;
        req_pin      = pin;
        req_amount   = amt[BAL_W-1:0];
        req_face_ok  = face;
        admin_unlock = unlock;
        @(negedge clk);
        req_valid    = 1'b0;
        admin_unlock = 1'b0;
    endtask

    // Compares every expected beat on every stalled cycle, then consumes it.
    task automatic collectBeats(input int stall);
        gotBeats.delete();
        for (int i = 0; i < expBeats.size(); i++) begin
            for (int s = 0; s <= stall; s++) begin
                if (s == 0) gotBeats.push_back('{rsp_status, int'(rsp_data), rsp_kind, rsp_last});
                checkOutput($sformatf("beat%0d stall%0d", i, s), packAct(), packExp(expBeats[i]));
                if (s == stall) rsp_ready = 1'b1;
                @(negedge clk);
                rsp_ready = 1'b0;
            end
        end
        checkOutput("rsp_valid after last beat", 32'(rsp_valid), 32'd0);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic [15:0] pin,
                                 input int amt, input bit face, input bit unlock,
                                 input int stall);
        modelStep(op, pin, amt, face, unlock);
        driveReq(op, pin, amt, face, unlock);
        collectBeats(stall);
        checkOutput("lock/session flags", {30'd0, account_locked, session_open},
                    {30'd0, mLocked, mSession});
    endtask

    task automatic pulseUnlock();
        admin_unlock = 1'b1;
        @(negedge clk);
        admin_unlock = 1'b0;
        mLocked   = 1'b0;
        mAttempts = 0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
    endtask

    task automatic expectFirst(input string name, input logic [2:0] st, input int data);
        logic [15:0] d;
        logic [15:0] g;
        d = data[15:0];
        g = gotBeats[0].data[15:0];
        checkOutput(name, {13'd0, gotBeats[0].status, g}, {13'd0, st, d});
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_op       = 3'd0;
        req_pin      = 16'd0;
        req_amount   = '0;
        req_face_ok  = 1'b0;
        admin_unlock = 1'b0;
        rsp_ready    = 1'b0;
        modelReset();

        // Directed table: {op, pin, amount, face, status, data, locked, session}
        vecs.push_back('{OP_BALANCE,   16'h0000,     0, 1'b0, ST_NO_SESSION,   0,     1'b0, 1'b0});
        vecs.push_back('{OP_VERIFY,    16'h1234,     0, 1'b0, ST_OK,           100,   1'b0, 1'b1});
        vecs.push_back('{OP_DEPOSIT,   16'h0000, 65535, 1'b0, ST_OVERFLOW,     0,     1'b0, 1'b1});
        vecs.push_back('{OP_BALANCE,   16'h0000,     0, 1'b0, ST_OK,           100,   1'b0, 1'b1});
        vecs.push_back('{OP_WITHDRAW,  16'h0000,     8, 1'b0, ST_OK,           92,    1'b0, 1'b1});
        vecs.push_back('{OP_DEPOSIT,   16'h0000,    20, 1'b0, ST_OK,           112,   1'b0, 1'b1});
        vecs.push_back('{OP_WITHDRAW,  16'h0000,    11, 1'b0, ST_NEED_FACE,    0,     1'b0, 1'b1});
        vecs.push_back('{OP_WITHDRAW,  16'h0000,    11, 1'b1, ST_OK,           101,   1'b0, 1'b1});
        vecs.push_back('{OP_WITHDRAW,  16'h0000,    10, 1'b0, ST_OK,           91,    1'b0, 1'b1});
        vecs.push_back('{OP_WITHDRAW,  16'h0000,    92, 1'b1, ST_INSUFFICIENT, 0,     1'b0, 1'b1});
        vecs.push_back('{OP_WITHDRAW,  16'h0000,    91, 1'b1, ST_OK,           0,     1'b0, 1'b1});
        vecs.push_back('{OP_DEPOSIT,   16'h0000,    79, 1'b0, ST_OK,           79,    1'b0, 1'b1});
        vecs.push_back('{OP_WITHDRAW,  16'h0000,    80, 1'b1, ST_INSUFFICIENT, 0,     1'b0, 1'b1});
        vecs.push_back('{OP_DEPOSIT,   16'h0000, 65456, 1'b0, ST_OK,           65535, 1'b0, 1'b1});
        vecs.push_back('{OP_DEPOSIT,   16'h0000,     1, 1'b0, ST_OVERFLOW,     0,     1'b0, 1'b1});
        vecs.push_back('{OP_WITHDRAW,  16'h0000, 65456, 1'b1, ST_OK,           79,    1'b0, 1'b1});
        vecs.push_back('{OP_BALANCE,   16'h0000,     0, 1'b0, ST_OK,           79,    1'b0, 1'b1});
        vecs.push_back('{3'd7,         16'h0000,     0, 1'b0, ST_UNSUPPORTED,  0,     1'b0, 1'b1});
        vecs.push_back('{OP_END,       16'h0000,     0, 1'b0, ST_OK,           79,    1'b0, 1'b0});
        vecs.push_back('{OP_DEPOSIT,   16'h0000,     5, 1'b0, ST_NO_SESSION,   0,     1'b0, 1'b0});
        vecs.push_back('{OP_VERIFY,    16'h0000,     0, 1'b0, ST_BAD_PIN,      0,     1'b0, 1'b0});
        vecs.push_back('{OP_VERIFY,    16'h0000,     0, 1'b0, ST_BAD_PIN,      0,     1'b0, 1'b0});
        vecs.push_back('{OP_VERIFY,    16'h0000,     0, 1'b0, ST_LOCKED,       0,     1'b1, 1'b0});
        vecs.push_back('{OP_VERIFY,    16'h1234,     0, 1'b0, ST_LOCKED,       0,     1'b1, 1'b0});

        repeat (2) @(negedge clk);
        checkOutput("reset rsp outputs", packAct(), 32'd0);
        checkOutput("reset ready/lock/session", {29'd0, req_ready, account_locked, session_open},
                    {29'd0, 3'b100});
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].op, vecs[i].pin, vecs[i].amt, vecs[i].face, 1'b0, i % 3);
            expectFirst($sformatf("vec%0d status/data", i), vecs[i].expStatus, vecs[i].expData);
            checkOutput($sformatf("vec%0d flags", i), {30'd0, account_locked, session_open},
                        {30'd0, vecs[i].expLocked, vecs[i].expSession});
        end

        // Unlock then verify succeeds again
        pulseUnlock();
        checkOutput("unlock clears lock", 32'(account_locked), 32'd0);
        applyStimulus(OP_VERIFY, PIN_VALUE, 0, 1'b0, 1'b0, 0);
        expectFirst("verify after unlock", ST_OK, 79);

        // Unlock coinciding with a bad PIN that would otherwise lock
        applyStimulus(OP_VERIFY, 16'h0000, 0, 1'b0, 1'b0, 0);
        applyStimulus(OP_VERIFY, 16'h0000, 0, 1'b0, 1'b0, 0);
        applyStimulus(OP_VERIFY, 16'h0000, 0, 1'b0, 1'b1, 0);
        expectFirst("bad pin with unlock", ST_BAD_PIN, 0);
        checkOutput("no lock with unlock", 32'(account_locked), 32'd0);
        applyStimulus(OP_VERIFY, 16'h0000, 0, 1'b0, 1'b0, 0);
        expectFirst("counter restarted 1", ST_BAD_PIN, 0);
        applyStimulus(OP_VERIFY, 16'h0000, 0, 1'b0, 1'b0, 0);
        expectFirst("counter restarted 2", ST_BAD_PIN, 0);
        applyStimulus(OP_VERIFY, 16'h0000, 0, 1'b0, 1'b0, 0);
        expectFirst("counter restarted 3", ST_LOCKED, 0);
        pulseUnlock();

        // Statement after five transactions, stalled three cycles per beat
        doReset();
        applyStimulus(OP_VERIFY, PIN_VALUE, 0, 1'b0, 1'b0, 0);
        applyStimulus(OP_DEPOSIT, 16'h0, 1, 1'b0, 1'b0, 0);
        applyStimulus(OP_WITHDRAW, 16'h0, 2, 1'b0, 1'b0, 0);
        applyStimulus(OP_DEPOSIT, 16'h0, 3, 1'b0, 1'b0, 0);
        applyStimulus(OP_DEPOSIT, 16'h0, 4, 1'b0, 1'b0, 0);
        applyStimulus(OP_WITHDRAW, 16'h0, 5, 1'b0, 1'b0, 0);
        applyStimulus(OP_STATEMENT, 16'h0, 0, 1'b0, 1'b0, 3);
`ifdef ATM_SERVER_HISTORY_EN
        checkOutput("stmt beat count", 32'(gotBeats.size()), 32'd4);
        if (gotBeats.size() == 4) begin
            checkOutput("stmt W5", {gotBeats[0].kind, gotBeats[0].last, 30'(gotBeats[0].data)}, {2'b00, 30'd5});
            checkOutput("stmt D4", {gotBeats[1].kind, gotBeats[1].last, 30'(gotBeats[1].data)}, {2'b10, 30'd4});
            checkOutput("stmt D3", {gotBeats[2].kind, gotBeats[2].last, 30'(gotBeats[2].data)}, {2'b10, 30'd3});
            checkOutput("stmt W2", {gotBeats[3].kind, gotBeats[3].last, 30'(gotBeats[3].data)}, {2'b01, 30'd2});
        end
`else
        expectFirst("statement unsupported", ST_UNSUPPORTED, 0);
`endif

        // Reset while a statement response is in flight
        modelStep(OP_STATEMENT, 16'h0, 0, 1'b0, 1'b0);
        driveReq(OP_STATEMENT, 16'h0, 0, 1'b0, 1'b0);
        checkOutput("stmt beat before reset", packAct(), packExp(expBeats[0]));
`ifdef ATM_SERVER_HISTORY_EN
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("stmt 2nd beat before reset", packAct(), packExp(expBeats[1]));
`endif
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset drops beat", packAct(), 32'd0);
        checkOutput("async reset ready/flags", {29'd0, req_ready, account_locked, session_open},
                    {29'd0, 3'b100});
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        @(negedge clk);
        applyStimulus(OP_BALANCE, 16'h0, 0, 1'b0, 1'b0, 0);
        expectFirst("no session after reset", ST_NO_SESSION, 0);
        applyStimulus(OP_VERIFY, PIN_VALUE, 0, 1'b0, 1'b0, 0);
        applyStimulus(OP_BALANCE, 16'h0, 0, 1'b0, 1'b0, 1);
        expectFirst("balance restored", ST_OK, 100);
        applyStimulus(OP_STATEMENT, 16'h0, 0, 1'b0, 1'b0, 1);
        checkOutput("stmt after reset beats", 32'(gotBeats.size()), 32'd1);
`ifdef ATM_SERVER_HISTORY_EN
        checkOutput("empty stmt beat", {gotBeats[0].kind, gotBeats[0].last, 27'(gotBeats[0].data), gotBeats[0].status},
                    {2'b01, 27'd0, ST_OK});
`else
        expectFirst("statement unsupported after reset", ST_UNSUPPORTED, 0);
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [2:0]  op;
            logic [15:0] pin;
            int          amt;
            if ($urandom_range(0, 99) < 5) pulseUnlock();
            op  = 3'($urandom_range(0, 7));
            if (!mSession && $urandom_range(0, 1) == 1) op = OP_VERIFY;
            pin = ($urandom_range(0, 3) != 0) ? PIN_VALUE : 16'($urandom);
            amt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(65500, 65535))
                                              : int'($urandom_range(0, 30));
            applyStimulus(op, pin, amt, 1'($urandom_range(0, 1)), 1'b0,
                          int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/atm_account_server.md
ATM_ACCOUNT_SERVER -- requirements
Module: atm_account_server

Interface
REQ-001 SHALL have parameters: BAL_W 16, balance/amount width; PIN_VALUE 16'h1234, account PIN; INIT_BALANCE 100, balance after reset; MAX_ATTEMPTS 3, bad-PIN count that locks the account; LIMIT 10, withdrawal amount above which face_ok is required; HIST_DEPTH 4, statement entries kept.
REQ-002 SHALL have ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_op  in  3  0 VERIFY_PIN, 1 DEPOSIT, 2 WITHDRAW, 3 BALANCE, 4 STATEMENT, 5 END_SESSION, 6-7 reserved.
- req_pin  in  16  PIN for VERIFY_PIN.
- req_amount  in  BAL_W  amount for DEPOSIT and WITHDRAW.
- req_face_ok  in  1  face verified, sampled with the request.
- admin_unlock  in  1  single-cycle pulse; clears lock.
- rsp_valid  out  1  response beat valid.
- rsp_ready  in  1  beat consumed when rsp_valid && rsp_ready.
- rsp_status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 NEED_FACE, 5 OVERFLOW, 6 NO_SESSION, 7 UNSUPPORTED.
- rsp_data  out  BAL_W  balance, or statement amount.
- rsp_kind  out  1  statement entry type: 1 deposit, 0 withdrawal.
- rsp_last  out  1  final beat of the response.
- account_locked  out  1  lock flag.
- session_open  out  1  PIN verified, session active.

Function
REQ-003 SHALL implement FSM IDLE -> RESP -> IDLE, plus IDLE -> STMT -> IDLE; req_ready=1 only in IDLE.
REQ-004 SHALL on acceptance in cycle N evaluate the request and present rsp_valid=1 in cycle N+1; outputs SHALL be held stable until rsp_ready.
REQ-005 SHALL make every non-STATEMENT response a single beat with rsp_last=1 and rsp_kind=0.
REQ-006 SHALL process VERIFY_PIN as follows:
- Locked: return LOCKED.
- PIN match: return OK, set session_open, clear the attempt counter.
- PIN mismatch: return BAD_PIN and increment the counter.
- Counter reaching MAX_ATTEMPTS: set account_locked in the same update and return LOCKED instead of BAD_PIN.
REQ-007 SHALL return NO_SESSION for ops 1-4 when session_open=0, with no state change.
REQ-008 SHALL process DEPOSIT as follows: if balance+amount exceeds 2^BAL_W-1, return OVERFLOW with the balance unchanged; otherwise add the amount and return OK with the new balance in rsp_data.
REQ-009 SHALL process WITHDRAW with checks in this order:
- amount > LIMIT and req_face_ok=0: return NEED_FACE.
- amount > balance: return INSUFFICIENT.
- Otherwise subtract the amount and return OK with the new balance.
- amount == LIMIT does not require face_ok.
- amount == balance is allowed and leaves a balance of 0.
REQ-010 SHALL return OK with the balance for BALANCE; SHALL clear session_open and return OK with the balance for END_SESSION; SHALL return UNSUPPORTED with no state change for ops 6-7.
REQ-011 SHALL record each OK DEPOSIT/WITHDRAW with non-zero amount in a circular history of HIST_DEPTH entries {kind, amount}; when full, the oldest entry is overwritten.
REQ-012 SHALL in STMT stream entries newest-first, one beat per rsp_ready handshake, status OK, with rsp_last on the oldest entry; an empty history SHALL produce one beat with rsp_data=0 and rsp_last=1.
REQ-013 SHALL handle admin_unlock in any state by clearing account_locked and the attempt counter; when it coincides with evaluation of a bad VERIFY_PIN, unlock wins: counter=0, lock=0, status BAD_PIN.
REQ-014 SHALL keep session_open=0 whenever account_locked=1.

Reset
REQ-015 SHALL on reset, asynchronously:
- Enter IDLE with req_ready=1.
- rsp_valid=0, rsp_status=0, rsp_data=0, rsp_kind=0, rsp_last=0.
- account_locked=0, session_open=0, attempt counter 0.
- balance=INIT_BALANCE, history emptied.
REQ-016 SHALL, when reset arrives mid-response or mid-STMT, drop the pending beats; no partial balance update SHALL survive.

Configuration
REQ-017 SHALL compile in the history buffer and STMT state only when ATM_SERVER_HISTORY_EN is defined; without it, STATEMENT SHALL return a single beat with UNSUPPORTED, rsp_last=1, and no history storage.

Verification
REQ-018 Correct PIN sequence: VERIFY 16'h1234 -> OK, session_open=1; WITHDRAW 8 -> OK, rsp_data 92; DEPOSIT 20 -> OK, 112.
REQ-019 Bad PIN sequence: three VERIFY 16'h0000 -> BAD_PIN, BAD_PIN, LOCKED with account_locked=1; VERIFY 16'h1234 -> LOCKED; admin_unlock, then VERIFY 16'h1234 -> OK.
REQ-020 Face check and limits, after verify: WITHDRAW 11 face_ok=0 -> NEED_FACE; WITHDRAW 11 face_ok=1 -> OK, 89; WITHDRAW 10 face_ok=0 -> OK, 79; WITHDRAW 80 -> INSUFFICIENT, balance 79.
REQ-021 Overflow: DEPOSIT 16'hFFFF with balance 100 -> OVERFLOW, balance 100; BALANCE before VERIFY -> NO_SESSION.
REQ-022 (ATM_SERVER_HISTORY_EN defined) Five OK transactions D1, W2, D3, D4, W5, then STATEMENT with rsp_ready held low 3 cycles -> beats stable while stalled, then W5, D4, D3, W2 with rsp_last on W2.
REQ-023 Reset mid-statement: reset asserted during the 2nd beat -> rsp_valid=0 immediately, balance 100, next STATEMENT after verify -> single empty beat.
